// File: rtl/typing_spawn_ctrl_if.sv
// Link between the game controller and the random-letter generator.
//   lfsr_en      : generator enable (controller -> generator)
//   lfsr_seed    : 32-bit seed, loaded by the generator while lfsr_en is low
//   lfsr_mode    : letter case mode
//   rnd_velocity : fall speed code, low two bits select the period
//   rnd_position : column 1..52
//   rnd_ascii    : character to spawn
//   rnd_linenum  : starting line (0 or 1)
// Handshake: there is no valid/ready pair. The generator loads lfsr_seed on any
// cycle with lfsr_en low, advances on every cycle with lfsr_en high, and its
// rnd_* outputs are treated as valid from the second enabled cycle onward.
interface typing_spawn_ctrl_if;
  logic        lfsr_en;
  logic [31:0] lfsr_seed;
  logic [1:0]  lfsr_mode;
  logic [7:0]  rnd_velocity;
  logic [5:0]  rnd_position;
  logic [7:0]  rnd_ascii;
  logic        rnd_linenum;

  modport master (
    output lfsr_en, lfsr_seed, lfsr_mode,
    input  rnd_velocity, rnd_position, rnd_ascii, rnd_linenum
  );

  modport slave (
    input  lfsr_en, lfsr_seed, lfsr_mode,
    output rnd_velocity, rnd_position, rnd_ascii, rnd_linenum
  );
endinterface

// File: rtl/typing_spawn_ctrl.sv
// Typing game controller: seeds and sequences the random-letter generator,
// keeps a table of falling letters, advances them on frame ticks, matches
// keyboard hits and counts score and misses until the game is over.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, mode_in      : start/restart pulse and case mode latched at start
//   tick                : frame tick pulse
//   key_valid/key_ascii : typed character pulse
//   gen                 : generator link (master side)
//   slot_*              : per-slot active flag, character, column, row
//                         (fields of inactive slots read as 0)
//   hit, miss           : registered one-cycle event pulses
//   score, miss_cnt     : game counters
//   game_over           : high in OVER
//   dbg_state           : FSM state (0 IDLE, 1 LOAD, 2 WARM, 3 RUN, 4 OVER)
module typing_spawn_ctrl #(
  parameter int NUM_SLOTS      = 8,
  parameter int SPAWN_INTERVAL = 20,
  parameter int BOTTOM_ROW     = 29,
  parameter int MAX_MISS       = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode_in,
  input  logic                   tick,
  input  logic                   key_valid,
  input  logic [7:0]             key_ascii,
  typing_spawn_ctrl_if.master    gen,
  output logic [NUM_SLOTS-1:0]   slot_active,
  output logic [8*NUM_SLOTS-1:0] slot_ascii,
  output logic [6*NUM_SLOTS-1:0] slot_col,
  output logic [5*NUM_SLOTS-1:0] slot_row,
  output logic                   hit,
  output logic                   miss,
  output logic [15:0]            score,
  output logic [3:0]             miss_cnt,
  output logic                   game_over,
  output logic [2:0]             dbg_state
);

  localparam int SCW = $clog2(SPAWN_INTERVAL + 1);
  localparam int IW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WARM = 3'd2,
    RUN  = 3'd3,
    OVER = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [31:0]    cyc_q;
  logic           warm_q;
  logic [SCW-1:0] spawn_cnt_q;
  logic [31:0]    seed_q;
  logic [1:0]     mode_q;

  logic [NUM_SLOTS-1:0] active_q;
  logic [7:0] asc_q [NUM_SLOTS];
  logic [5:0] col_q [NUM_SLOTS];
  logic [4:0] row_q [NUM_SLOTS];
  logic [2:0] per_q [NUM_SLOTS];
  logic [2:0] sub_q [NUM_SLOTS];

  // Combinational decisions, all taken on pre-update slot state
  logic                 run;
  logic                 hit_now;
  logic [IW-1:0]        hit_idx;
  logic [4:0]           best_row;
  logic                 free_found;
  logic [IW-1:0]        free_idx;
  logic                 do_spawn;
  logic [NUM_SLOTS-1:0] step;
  logic [NUM_SLOTS-1:0] wrap;
  logic [NUM_SLOTS-1:0] drop;
  logic [4:0]           drop_count;
  logic [4:0]           miss_sum;
  logic [3:0]           miss_next;
  logic                 go_over;

  logic unused_vel;
  assign unused_vel = ^gen.rnd_velocity[7:2];

  assign run = (state_q == RUN);

  always_comb begin
    hit_now    = 1'b0;
    hit_idx    = '0;
    best_row   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    // Largest row wins; strict compare keeps the lowest index on ties.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (run && key_valid && active_q[i] && asc_q[i] == key_ascii) begin
        if (!hit_now || row_q[i] > best_row) begin
          hit_now  = 1'b1;
          hit_idx  = IW'(i);
          best_row = row_q[i];
        end
      end
      if (!active_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign do_spawn = run && tick && (spawn_cnt_q <= SCW'(1)) && free_found;

  always_comb begin
    step       = '0;
    wrap       = '0;
    drop       = '0;
    drop_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      // The slot being hit this cycle is frozen: no movement, no miss.
      step[i] = run && tick && active_q[i] && !(hit_now && hit_idx == IW'(i));
      wrap[i] = (sub_q[i] + 3'd1) == per_q[i];
      drop[i] = step[i] && wrap[i] && (row_q[i] == 5'(BOTTOM_ROW));
      drop_count = drop_count + 5'(drop[i]);
    end
  end

  assign miss_sum  = {1'b0, miss_cnt} + drop_count;
  assign miss_next = (miss_sum >= 5'(MAX_MISS)) ? 4'(MAX_MISS) : miss_sum[3:0];
  assign go_over   = run && (|drop) && (miss_next == 4'(MAX_MISS));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OVER: if (start) state_d = LOAD;
      LOAD:       state_d = WARM;
      WARM:       if (warm_q) state_d = RUN;
      RUN:        if (go_over) state_d = OVER;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q       <= '0;
      warm_q      <= 1'b0;
      spawn_cnt_q <= '0;
      seed_q      <= '0;
      mode_q      <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      score       <= '0;
      miss_cnt    <= '0;
      active_q    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        asc_q[i] <= '0;
        col_q[i] <= '0;
        row_q[i] <= '0;
        per_q[i] <= '0;
        sub_q[i] <= '0;
      end
    end else begin
      cyc_q  <= cyc_q + 32'd1;
      hit    <= 1'b0;
      miss   <= 1'b0;
      // Two WARM cycles: warm_q marks the second one.
      warm_q <= (state_q == WARM) ? ~warm_q : 1'b0;

      if ((state_q == IDLE || state_q == OVER) && start) begin
        seed_q      <= cyc_q;
        mode_q      <= mode_in;
        active_q    <= '0;
        score       <= '0;
        miss_cnt    <= '0;
        spawn_cnt_q <= SCW'(SPAWN_INTERVAL);
      end

      if (run) begin
        if (hit_now) begin
          hit <= 1'b1;
          if (score != 16'hFFFF) score <= score + 16'd1;
        end
        if (tick) begin
          // With no free slot the counter parks at 0 and retries every tick.
          if (spawn_cnt_q <= SCW'(1))
            spawn_cnt_q <= free_found ? SCW'(SPAWN_INTERVAL) : '0;
          else
            spawn_cnt_q <= spawn_cnt_q - SCW'(1);
        end
        if (|drop) begin
          miss     <= 1'b1;
          miss_cnt <= miss_next;
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (hit_now && hit_idx == IW'(i)) begin
            active_q[i] <= 1'b0;
          end else if (drop[i]) begin
            active_q[i] <= 1'b0;
            sub_q[i]    <= '0;
          end else if (step[i]) begin
            if (wrap[i]) begin
              sub_q[i] <= '0;
              row_q[i] <= row_q[i] + 5'd1;
            end else begin
              sub_q[i] <= sub_q[i] + 3'd1;
            end
          end
          // Spawn target was free before this cycle, so it never collides
          // with the hit/move/drop updates above.
          if (do_spawn && free_idx == IW'(i)) begin
            active_q[i] <= 1'b1;
            asc_q[i]    <= gen.rnd_ascii;
            col_q[i]    <= gen.rnd_position;
            row_q[i]    <= {4'b0, gen.rnd_linenum};
            per_q[i]    <= {1'b0, gen.rnd_velocity[1:0]} + 3'd1;
            sub_q[i]    <= '0;
          end
          if (go_over) active_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    slot_ascii = '0;
    slot_col   = '0;
    slot_row   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (active_q[i]) begin
        slot_ascii[8*i +: 8] = asc_q[i];
        slot_col[6*i +: 6]   = col_q[i];
        slot_row[5*i +: 5]   = row_q[i];
      end
    end
  end

  assign slot_active   = active_q;
  assign gen.lfsr_en   = (state_q == WARM) || (state_q == RUN);
  assign gen.lfsr_seed = seed_q;
  assign gen.lfsr_mode = mode_q;
  assign game_over     = (state_q == OVER);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_typing_spawn_ctrl.sv
module tb_typing_spawn_ctrl;

  localparam int NS = 4;
  localparam int SI = 2;
  localparam int BR = 12;
  localparam int MM = 3;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_WARM = 2;
  localparam int S_RUN  = 3;
  localparam int S_OVER = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [1:0]  mode_in = '0;
  logic        tick = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_ascii = '0;

  logic [NS-1:0]   slot_active;
  logic [8*NS-1:0] slot_ascii;
  logic [6*NS-1:0] slot_col;
  logic [5*NS-1:0] slot_row;
  logic            hit, miss, game_over;
  logic [15:0]     score;
  logic [3:0]      miss_cnt;
  logic [2:0]      dbg_state;

  typing_spawn_ctrl_if gen_if ();

  typing_spawn_ctrl #(
    .NUM_SLOTS(NS), .SPAWN_INTERVAL(SI), .BOTTOM_ROW(BR), .MAX_MISS(MM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .tick(tick),
    .key_valid(key_valid), .key_ascii(key_ascii), .gen(gen_if),
    .slot_active(slot_active), .slot_ascii(slot_ascii), .slot_col(slot_col),
    .slot_row(slot_row), .hit(hit), .miss(miss), .score(score),
    .miss_cnt(miss_cnt), .game_over(game_over), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];   // expected score after each hit pulse
  int n_hits = 0, n_miss = 0, n_over = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_cnt;
  int m_state, m_warm, m_seed, m_mode, m_score, m_misses, m_spawn;
  bit m_hit, m_miss;
  bit m_act[NS];
  int m_asc[NS], m_col[NS], m_row[NS], m_per[NS], m_sub[NS];

  task automatic run_step();
    bit p_act[NS];
    int hit_i, spawn_i, drops;
    p_act = m_act;
    hit_i = -1;
    spawn_i = -1;
    drops = 0;
    if (key_valid) begin
      for (int i = 0; i < NS; i++)
        if (p_act[i] && m_asc[i] == int'(key_ascii))
          if (hit_i < 0 || m_row[i] > m_row[hit_i]) hit_i = i;
      if (hit_i >= 0) begin
        m_act[hit_i] = 0;
        m_hit = 1;
        if (m_score < 65535) m_score++;
        exp_q.push_back(16'(m_score));
      end
    end
    if (tick) begin
      if (m_spawn <= 1) begin
        for (int i = NS - 1; i >= 0; i--) if (!p_act[i]) spawn_i = i;
        m_spawn = (spawn_i >= 0) ? SI : 0;
      end else begin
        m_spawn--;
      end
      for (int i = 0; i < NS; i++) begin
        if (p_act[i] && i != hit_i) begin
          m_sub[i]++;
          if (m_sub[i] == m_per[i]) begin
            m_sub[i] = 0;
            if (m_row[i] == BR) begin
              m_act[i] = 0;
              drops++;
            end else begin
              m_row[i]++;
            end
          end
        end
      end
      if (spawn_i >= 0) begin
        m_act[spawn_i] = 1;
        m_asc[spawn_i] = int'(gen_if.rnd_ascii);
        m_col[spawn_i] = int'(gen_if.rnd_position);
        m_row[spawn_i] = int'(gen_if.rnd_linenum);
        m_per[spawn_i] = int'(gen_if.rnd_velocity % 8'd4) + 1;
        m_sub[spawn_i] = 0;
      end
      if (drops > 0) begin
        m_miss = 1;
        m_misses = (m_misses + drops > MM) ? MM : m_misses + drops;
        if (m_misses == MM) begin
          m_state = S_OVER;
          for (int i = 0; i < NS; i++) m_act[i] = 0;
        end
      end
    end
  endtask

  // Computes the state expected after the coming clock edge from the
  // inputs currently driven.
  task automatic model_step();
    m_hit = 0;
    m_miss = 0;
    if (rst) begin
      m_cnt = 0; m_state = S_IDLE; m_warm = 0; m_seed = 0; m_mode = 0;
      m_score = 0; m_misses = 0; m_spawn = 0;
      for (int i = 0; i < NS; i++) begin
        m_act[i] = 0; m_asc[i] = 0; m_col[i] = 0; m_row[i] = 0;
        m_per[i] = 0; m_sub[i] = 0;
      end
      return;
    end
    case (m_state)
      S_IDLE, S_OVER: if (start) begin
        m_seed = int'(m_cnt);
        m_mode = int'(mode_in);
        for (int i = 0; i < NS; i++) m_act[i] = 0;
        m_score = 0; m_misses = 0; m_spawn = SI;
        m_state = S_LOAD;
      end
      S_LOAD: begin m_state = S_WARM; m_warm = 0; end
      S_WARM: if (m_warm != 0) m_state = S_RUN; else m_warm = 1;
      S_RUN:  run_step();
      default: m_state = S_IDLE;
    endcase
    m_cnt++;
  endtask

  task automatic compare_all();
    logic [63:0] e_act, e_asc, e_col, e_row, k_asc, k_col, k_row;
    e_act = '0; e_asc = '0; e_col = '0; e_row = '0;
    k_asc = '0; k_col = '0; k_row = '0;
    for (int i = 0; i < NS; i++) begin
      e_act[i] = m_act[i];
      if (m_act[i]) begin
        e_asc[8*i +: 8] = 8'(m_asc[i]); k_asc[8*i +: 8] = 8'hFF;
        e_col[6*i +: 6] = 6'(m_col[i]); k_col[6*i +: 6] = 6'h3F;
        e_row[5*i +: 5] = 5'(m_row[i]); k_row[5*i +: 5] = 5'h1F;
      end
    end
    check("active", 64'(slot_active), e_act);
    check("ascii", 64'(slot_ascii) & k_asc, e_asc);
    check("col", 64'(slot_col) & k_col, e_col);
    check("row", 64'(slot_row) & k_row, e_row);
    check("hit", 64'(hit), 64'(m_hit));
    check("miss", 64'(miss), 64'(m_miss));
    check("score", 64'(score), 64'(m_score));
    check("miss_cnt", 64'(miss_cnt), 64'(m_misses));
    check("game_over", 64'(game_over), 64'(m_state == S_OVER));
    check("lfsr_en", 64'(gen_if.lfsr_en), 64'(m_state == S_WARM || m_state == S_RUN));
    check("lfsr_seed", 64'(gen_if.lfsr_seed), 64'(32'(m_seed)));
    check("lfsr_mode", 64'(gen_if.lfsr_mode), 64'(m_mode));
    check("state", 64'(dbg_state), 64'(m_state));
    if (hit) begin
      if (exp_q.size() == 0) check("hit_unexpected", 64'(hit), 64'(0));
      else check("hit_score", 64'(score), 64'(exp_q.pop_front()));
    end
    if (m_hit) n_hits++;
    if (m_miss) n_miss++;
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive_idle();
    start = 0; tick = 0; key_valid = 0; rst = 0;
  endtask

  task automatic drive_random();
    rst       = ($urandom_range(0, 2999) == 0);
    start     = ($urandom_range(0, 39) == 0);
    mode_in   = 2'($urandom_range(0, 3));
    tick      = 1'($urandom_range(0, 1));
    key_valid = ($urandom_range(0, 5) == 0);
    key_ascii = 8'h61 + 8'($urandom_range(0, 3));
    gen_if.rnd_ascii    = 8'h61 + 8'($urandom_range(0, 2));
    gen_if.rnd_position = 6'($urandom_range(1, 52));
    gen_if.rnd_linenum  = 1'($urandom_range(0, 1));
    gen_if.rnd_velocity = 8'($urandom);
  endtask

  initial begin
    int guard;
    bit was_over;
    gen_if.rnd_ascii = 8'h61; gen_if.rnd_position = 6'd5;
    gen_if.rnd_linenum = 1'b1; gen_if.rnd_velocity = 8'd0;

    rst = 1;
    repeat (3) cycle();
    check("rst_active", 64'(slot_active), 64'(0));
    check("rst_score", 64'(score), 64'(0));
    check("rst_seed", 64'(gen_if.lfsr_seed), 64'(0));
    check("rst_en", 64'(gen_if.lfsr_en), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));

    // Start on the edge where the cycle counter holds 100.
    drive_idle();
    guard = 0;
    while (m_cnt != 100 && guard < 200) begin
      cycle();
      guard++;
    end
    start = 1;
    cycle();
    start = 0;
    check("seed100", 64'(gen_if.lfsr_seed), 64'(100));
    check("load_en", 64'(gen_if.lfsr_en), 64'(0));
    cycle();
    check("warm_en", 64'(gen_if.lfsr_en), 64'(1));
    cycle();
    cycle();
    check("run_after_3", 64'(dbg_state), 64'(S_RUN));

    was_over = 0;
    for (int n = 0; n < 30000; n++) begin
      drive_random();
      cycle();
      if (game_over && !was_over) n_over++;
      was_over = game_over;
    end
    drive_idle();
    cycle();
    check("hit_q_drain", 64'(exp_q.size()), 64'(0));

    $display("info: hits=%0d miss_events=%0d games_over=%0d", n_hits, n_miss, n_over);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/typing_spawn_ctrl.md
Name: typing_spawn_ctrl

Overview:
- Game-side controller for the typing game's random-letter generator (seeded LFSR producing velocity/position/ASCII/line per enabled cycle).
- Sequences the generator: latches a seed, gates its enable, and samples its outputs at spawn time.
- Keeps a table of falling letters, advances them on frame ticks, matches keyboard hits, and counts score/misses until game over.
- Sits between the keyboard decoder, frame-tick source, random generator and the VGA text renderer.

Parameters:
- NUM_SLOTS, 8, number of concurrently falling letters (1..16)
- SPAWN_INTERVAL, 20, frame ticks between spawn attempts (≥1)
- BOTTOM_ROW, 29, last visible row; a letter leaving it is a miss (≤31)
- MAX_MISS, 10, misses that end the game (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: begin or restart a game
- mode_in  in  2  letter case mode, latched at start
- tick  in  1  one-cycle frame tick
- key_valid  in  1  one-cycle pulse, key_ascii valid
- key_ascii  in  8  typed character
- rnd_velocity  in  8  generator velocity output
- rnd_position  in  6  generator column output (1..52)
- rnd_ascii  in  8  generator character output
- rnd_linenum  in  1  generator line output
- lfsr_en  out  1  generator enable
- lfsr_seed  out  32  generator seed
- lfsr_mode  out  2  generator mode
- slot_active  out  NUM_SLOTS  per-slot occupied flag
- slot_ascii  out  8*NUM_SLOTS  per-slot character, slot i at [8i+7:8i]
- slot_col  out  6*NUM_SLOTS  per-slot column
- slot_row  out  5*NUM_SLOTS  per-slot row
- hit  out  1  one-cycle pulse on a matched key
- miss  out  1  one-cycle pulse when any letter falls off
- score  out  16  hits this game, saturating at 16'hFFFF
- miss_cnt  out  4  misses this game
- game_over  out  1  high in OVER state

Behaviour:
- Reset: state IDLE; all outputs 0; free-running 32-bit cycle counter cleared, counts every cycle otherwise.
- States: IDLE, LOAD, WARM, RUN, OVER. lfsr_en=1 only in WARM and RUN.
- IDLE/OVER + start: lfsr_seed <= cycle counter, lfsr_mode <= mode_in. Clear slots, score, miss_cnt and spawn counter (to SPAWN_INTERVAL). Go to LOAD.
- start in LOAD/WARM/RUN is ignored.
- LOAD: 1 cycle with lfsr_en=0 and the new seed stable, so the generator loads it. Then WARM.
- WARM: 2 cycles, so rnd_* outputs are valid. Then RUN. tick and key_valid are ignored in LOAD and WARM.
- RUN, tick: spawn counter decrements.
  - Counter at 1 (or held at 0): spawn into the lowest-index slot free before this cycle's updates.
  - Spawned slot: ascii=rnd_ascii, col=rnd_position, row={4'b0,rnd_linenum}, period=rnd_velocity[1:0]+1, sub-counter=0.
  - Counter then reloads SPAWN_INTERVAL. If no slot is free, the counter holds 0 and spawning retries on every tick.
- RUN, tick, movement (each active slot not spawned this cycle): sub-counter++. When it reaches period: sub-counter=0 and row++.
  - If row==BOTTOM_ROW at that step, the slot is cleared instead of moving. miss=1 (single pulse even if several slots drop); miss_cnt += number of dropped slots, saturating at MAX_MISS.
- RUN, key_valid: candidates are active slots with ascii==key_ascii. Select the largest row, ties to the lowest index.
  - Selected slot is cleared; hit=1; score++.
  - No match: no effect (no penalty).
- Simultaneous key hit and tick: the hit is evaluated on pre-update state and wins. The hit slot neither moves nor counts a miss.
- A slot freed this cycle by hit or miss is not reusable for a spawn until a later tick.
- miss_cnt reaching MAX_MISS: next state OVER.
  - In OVER: lfsr_en=0, slot_active cleared, score and miss_cnt held, game_over=1.
- hit and miss are registered, one-cycle pulses.
- rst mid-game returns to IDLE with everything cleared on the next edge.

Test Plan:
- Reset then start at cycle count 100 -> lfsr_seed=100 (captured on the start edge), lfsr_en low 1 cycle then high, RUN reached 3 cycles after start.
- SPAWN_INTERVAL=2, rnd_ascii=8'h61, rnd_position=5, rnd_linenum=1, rnd_velocity=0, 2 ticks -> slot0 active, ascii 'a', col 5, row 1. Next tick -> row 2.
- Slots 0 and 3 both hold 'b', rows 4 and 9; key_valid with 8'h62 -> slot3 cleared, hit pulse, score=1, slot0 unchanged.
- Letter at row BOTTOM_ROW with period 1, tick -> slot cleared, miss pulse, miss_cnt+1. Same letter hit on that tick cycle -> hit, no miss.
- All NUM_SLOTS full at spawn time -> no spawn, counter held at 0. Hit frees slot 2 -> slot 2 is filled on the next tick.
- MAX_MISS=2, two misses -> game_over=1, lfsr_en=0, score held. start -> LOAD, counters 0, game_over=0.
